load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-serial RV32I load/store unit: one memory byte per ACCESS cycle,
// little-endian, with accept-time error classification and load extension.
module load_store_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wr_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [7:0]        mem_rd_data,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_k;
    logic [1:0]          r_last;
    logic [1:0]          r_err;
    logic                r_store;
    logic [2:0]          r_f3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_data;

    logic                w_acc;
    logic                w_access;
    logic                w_illegal;
    logic                w_mis;
    logic                w_fault;
    logic [1:0]          w_last;
    logic [1:0]          w_err;
    logic [ADDR_W-1:0]   w_max_base;
    logic [31:0]         w_ext;

    assign req_ready = (r_state == IDLE) && !rst;
    assign w_acc     = req_valid && req_ready;
    assign w_access  = (r_state == ACCESS);
    assign busy      = (r_state != IDLE);

    always_comb begin
        w_last    = 2'd0;
        w_illegal = 1'b0;
        w_mis     = 1'b0;
        case (req_funct3)
            3'b000: w_last = 2'd0;
            3'b100: w_illegal = req_store;
            3'b001: begin
                w_last = 2'd1;
                w_mis  = req_addr[0];
            end
            3'b101: begin
                w_last    = 2'd1;
                w_mis     = req_addr[0];
                w_illegal = req_store;
            end
            3'b010: begin
                w_last = 2'd3;
                w_mis  = |req_addr[1:0];
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Highest base address whose last byte still fits below 2^ADDR_W.
    assign w_max_base = {ADDR_W{1'b1}} - ADDR_W'(w_last);
    assign w_fault    = (|req_addr[31:ADDR_W])
                     || (req_addr[ADDR_W-1:0] > w_max_base);

    always_comb begin
        w_err = 2'b00;
        if (w_illegal)
            w_err = 2'b11;
        else if (w_mis)
            w_err = 2'b01;
        else if (w_fault)
            w_err = 2'b10;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_acc)
                    w_next = (w_err != 2'b00) ? DONE : ACCESS;
            end
            ACCESS: begin
                if (r_k == r_last)
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k     <= 2'd0;
            r_last  <= 2'd0;
            r_err   <= 2'b00;
            r_store <= 1'b0;
            r_f3    <= 3'b000;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_data  <= 32'h0;
        end else if (r_state == IDLE) begin
            if (w_acc) begin
                r_k     <= 2'd0;
                r_last  <= w_last;
                r_err   <= w_err;
                r_store <= req_store;
                r_f3    <= req_funct3;
                r_addr  <= req_addr[ADDR_W-1:0];
                r_wdata <= req_wdata;
                r_data  <= 32'h0;
            end
        end else if (w_access) begin
            r_k <= r_k + 2'd1;
            if (!r_store)
                r_data[{r_k, 3'b000} +: 8] <= mem_rd_data;
        end
    end

    assign mem_addr    = w_access ? r_addr + ADDR_W'(r_k) : '0;
    assign mem_wr_data = w_access ? r_wdata[{r_k, 3'b000} +: 8] : 8'h00;
    assign mem_read    = w_access && !r_store;
    assign mem_write   = w_access && r_store;

    always_comb begin
        case (r_f3)
            3'b000:  w_ext = {{24{r_data[7]}}, r_data[7:0]};
            3'b100:  w_ext = {24'h0, r_data[7:0]};
            3'b001:  w_ext = {{16{r_data[15]}}, r_data[15:0]};
            3'b101:  w_ext = {16'h0, r_data[15:0]};
            default: w_ext = r_data;
        endcase
    end

    assign resp_valid = (r_state == DONE);
    assign resp_err   = resp_valid ? r_err : 2'b00;
    assign resp_rdata = (resp_valid && r_err == 2'b00 && !r_store)
                      ? w_ext : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// responses and strobe patterns; a negedge monitor pops and compares.
module tb_load_store_unit;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_store = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wr_data;
    logic [7:0]    mem_rd_data;
    logic          mem_read;
    logic          mem_write;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic [1:0]    resp_err;
    logic          busy;

    load_store_unit #(.ADDR_W(AW)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_store(req_store),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_rd_data(mem_rd_data),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        store;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  err;
        int          n;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   strobe_cnt = 0;
    int   last_acc_cyc = -1;
    int   last_resp_cyc = -1;
    logic inflight = 1'b0;

    logic [7:0] mem [0:(1<<AW)-1];
    logic       pre_we = 1'b0;
    logic [9:0] pre_addr = 10'h0;
    logic [7:0] pre_data = 8'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write)
            mem[mem_addr] <= mem_wr_data;
        else if (pre_we)
            mem[pre_addr] <= pre_data;
    end

    assign mem_rd_data = mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    initial begin
        exp_t e;
        int   a;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                if (exp_q.size() == 0) begin
                    chk("stray_strobe", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    chk("strobe_addr", 32'(mem_addr),
                        exp_q[0].addr + 32'(strobe_cnt));
                    chk("strobe_kind", 32'(mem_write), 32'(exp_q[0].store));
                    chk("strobe_excl", 32'(mem_read & mem_write), 32'h0);
                    if (exp_q[0].store)
                        chk("wr_byte", 32'(mem_wr_data),
                            (exp_q[0].wdata >> (8 * strobe_cnt)) & 32'hFF);
                    strobe_cnt++;
                end
            end
            if (rst) begin
                inflight = 1'b0;
            end else begin
                chk("busy", 32'(busy), 32'(inflight));
            end
            if (resp_valid) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    chk("stray_resp", resp_rdata, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("rdata", resp_rdata, e.rdata);
                    chk("err", 32'(resp_err), 32'(e.err));
                    chk("latency", 32'(cyc - a), 32'(e.lat));
                    chk("strobes", 32'(strobe_cnt), 32'(e.n));
                end
                strobe_cnt    = 0;
                last_resp_cyc = cyc;
                inflight      = 1'b0;
            end
            if (req_valid && req_ready) begin
                acc_q.push_back(cyc);
                last_acc_cyc = cyc;
                inflight     = 1'b1;
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [1:0] err,
                         input int n, input logic hold);
        exp_t e;
        bit   ok;
        e.store = st;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = rdata;
        e.err   = err;
        e.n     = (err != 2'b00) ? 0 : n;
        e.lat   = (err != 2'b00) ? 1 : n + 1;
        exp_q.push_back(e);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            chk("accept_timeout", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        if (!hold)
            req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 30) begin
            @(posedge clk);
            i++;
        end
        if (exp_q.size() != 0) begin
            chk("resp_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
            acc_q.delete();
            strobe_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic chk_mem(input logic [9:0] a, input logic [7:0] d);
        chk($sformatf("mem[%h]", a), 32'(mem[a]), 32'(d));
    endtask

    task automatic chk_rst_outs(input logic ready);
        chk("rst_req_ready", 32'(req_ready), 32'(ready));
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_mem_read", 32'(mem_read), 32'h0);
        chk("rst_mem_write", 32'(mem_write), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wr_data", 32'(mem_wr_data), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_rst_outs(1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_rst_outs(1'b1);
        @(posedge clk);
        #1;

        // word store then word load
        issue(1'b1, 3'b010, 32'h10, 32'hA1B2C3D4, 32'h0, 2'b00, 4, 1'b0);
        wait_done();
        chk_mem(10'h10, 8'hD4);
        chk_mem(10'h11, 8'hC3);
        chk_mem(10'h12, 8'hB2);
        chk_mem(10'h13, 8'hA1);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hA1B2C3D4, 2'b00, 4, 1'b0);
        wait_done();

        // byte/half extension
        preload(10'h20, 8'h80);
        preload(10'h21, 8'hFF);
        issue(1'b0, 3'b000, 32'h20, 32'h0, 32'hFFFFFF80, 2'b00, 1, 1'b0);
        wait_done();
        issue(1'b0, 3'b100, 32'h20, 32'h0, 32'h00000080, 2'b00, 1, 1'b0);
        wait_done();
        issue(1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFFFF80, 2'b00, 2, 1'b0);
        wait_done();
        issue(1'b0, 3'b101, 32'h20, 32'h0, 32'h0000FF80, 2'b00, 2, 1'b0);
        wait_done();

        // error paths
        issue(1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 2'b01, 0, 1'b0);
        wait_done();
        issue(1'b0, 3'b001, 32'h3FF, 32'h0, 32'h0, 2'b01, 0, 1'b0);
        wait_done();
        issue(1'b0, 3'b000, 32'h400, 32'h0, 32'h0, 2'b10, 0, 1'b0);
        wait_done();
        issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 2'b11, 0, 1'b0);
        wait_done();
        issue(1'b1, 3'b100, 32'h10, 32'h55, 32'h0, 2'b11, 0, 1'b0);
        wait_done();
        issue(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h0, 2'b10, 0, 1'b0);
        wait_done();
        issue(1'b1, 3'b001, 32'h3FE, 32'h0, 32'h0, 2'b00, 2, 1'b0);
        wait_done();
        chk_mem(10'h3FE, 8'h00);
        chk_mem(10'h3FF, 8'h00);

        // back-to-back with req_valid held high
        preload(10'h31, 8'h12);
        preload(10'h32, 8'h34);
        preload(10'h33, 8'h56);
        issue(1'b1, 3'b000, 32'h30, 32'hCAFE0077, 32'h0, 2'b00, 1, 1'b1);
        issue(1'b0, 3'b010, 32'h30, 32'h0, 32'h56341277, 2'b00, 4, 1'b0);
        chk("b2b_accept_cycle", 32'(last_acc_cyc), 32'(last_resp_cyc + 1));
        wait_done();

        // reset in the middle of a word store
        preload(10'h40, 8'hEE);
        preload(10'h41, 8'hEE);
        preload(10'h42, 8'h5A);
        preload(10'h43, 8'hA5);
        issue(1'b1, 3'b010, 32'h40, 32'h11223344, 32'h0, 2'b00, 4, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        acc_q.delete();
        strobe_cnt = 0;
        @(negedge clk);
        chk_rst_outs(1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_rst_outs(1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk_mem(10'h40, 8'h44);
        chk_mem(10'h41, 8'h33);
        chk_mem(10'h42, 8'h5A);
        chk_mem(10'h43, 8'hA5);

        // upper boundary
        preload(10'h3FC, 8'h01);
        preload(10'h3FD, 8'h02);
        preload(10'h3FE, 8'h03);
        preload(10'h3FF, 8'h84);
        issue(1'b0, 3'b010, 32'h3FC, 32'h0, 32'h84030201, 2'b00, 4, 1'b0);
        wait_done();
        issue(1'b0, 3'b000, 32'h3FF, 32'h0, 32'hFFFFFF84, 2'b00, 1, 1'b0);
        wait_done();
        issue(1'b0, 3'b101, 32'h3FE, 32'h0, 32'h00008403, 2'b00, 2, 1'b0);
        wait_done();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
